// File: rtl/seq_pkg.sv
// seq_pkg: shared state encodings for the sequence generator and detector.
package seq_pkg;
  typedef enum logic [1:0] {IDLE, SEND, GAP, FIN} state_t;
  typedef enum logic [1:0] {DET_IDLE, DET_S1, DET_S10, DET_HIT} det_state_t;
endpackage

// File: rtl/seq_pattern_gen_if.sv
// seq_pattern_gen_if: control and serial-output bundle of the pattern generator.
interface seq_pattern_gen_if #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4,
  parameter int REP_W = 8,
  parameter int GAP_W = 4
);
  logic             start;
  logic             abort;
  logic [PAT_W-1:0] pat;
  logic [LEN_W-1:0] len;
  logic [REP_W-1:0] reps;
  logic [GAP_W-1:0] gap;
  logic             out;
  logic             out_valid;
  logic             frame_sof;
  logic             busy;
  logic             done;
  modport master (output start, abort, pat, len, reps, gap,
                  input  out, out_valid, frame_sof, busy, done);
  modport slave  (input  start, abort, pat, len, reps, gap,
                  output out, out_valid, frame_sof, busy, done);
endinterface

// File: rtl/seq_down_cnt.sv
// seq_down_cnt: loadable down-counter that saturates at zero.
module seq_down_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic         i_dec,
  input  logic [W-1:0] i_val,
  output logic [W-1:0] o_cnt,
  output logic         o_zero
);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_cnt <= '0;
    else if (i_load) r_cnt <= i_val;
    else if (i_dec && !o_zero) r_cnt <= r_cnt - 1'b1;
  assign o_cnt  = r_cnt;
  assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: serial MSB-first pattern transmitter with repeat count and inter-frame gap.
module seq_pattern_gen
  import seq_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4,
  parameter int REP_W = 8,
  parameter int GAP_W = 4
) (
  input logic               clk,
  input logic               rst,
  seq_pattern_gen_if.slave  bus
);
  state_t           r_state, w_nxt;
  logic [PAT_W-1:0] r_pat, w_src, w_shift;
  logic [LEN_W-1:0] r_len, w_len_c, w_idx, w_bit_cnt;
  logic [GAP_W-1:0] r_gap, w_gap_cnt;
  logic [REP_W-1:0] w_frm_cnt;
  logic w_latch, w_sof;
  logic w_bit_load, w_bit_dec, w_bit_zero;
  logic w_gap_load, w_gap_dec, w_gap_zero;
  logic w_frm_load, w_frm_dec, w_frm_zero;
  logic r_out, r_valid, r_sof, r_busy, r_done;
  logic w_unused;

  assign w_len_c  = (bus.len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : bus.len;
  assign w_shift  = w_src >> w_idx;
  assign w_unused = ^{w_gap_cnt, w_frm_cnt, w_shift[PAT_W-1:1]};

  // w_idx is both the next bit to drive and the bit counter's load value
  always_comb begin
    w_nxt      = r_state;
    w_latch    = 1'b0;
    w_sof      = 1'b0;
    w_src      = r_pat;
    w_idx      = w_bit_cnt - 1'b1;
    w_bit_load = 1'b0;
    w_bit_dec  = 1'b0;
    w_gap_load = 1'b0;
    w_gap_dec  = 1'b0;
    w_frm_load = 1'b0;
    w_frm_dec  = 1'b0;
    unique case (r_state)
      IDLE: if (bus.start) begin
        w_latch = 1'b1;
        if (w_len_c == '0 || bus.reps == '0) w_nxt = FIN;
        else begin
          w_nxt      = SEND;
          w_src      = bus.pat;
          w_idx      = w_len_c - 1'b1;
          w_sof      = 1'b1;
          w_bit_load = 1'b1;
          w_frm_load = 1'b1;
        end
      end
      SEND:
        if (bus.abort) w_nxt = IDLE;
        else if (!w_bit_zero) w_bit_dec = 1'b1;
        else if (w_frm_zero) w_nxt = FIN;
        else begin
          w_frm_dec = 1'b1;
          if (r_gap == '0) begin
            w_idx      = r_len - 1'b1;
            w_sof      = 1'b1;
            w_bit_load = 1'b1;
          end else begin
            w_nxt      = GAP;
            w_gap_load = 1'b1;
          end
        end
      GAP:
        if (bus.abort) w_nxt = IDLE;
        else if (w_gap_zero) begin
          w_nxt      = SEND;
          w_idx      = r_len - 1'b1;
          w_sof      = 1'b1;
          w_bit_load = 1'b1;
        end else w_gap_dec = 1'b1;
      FIN: w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  seq_down_cnt #(.W(LEN_W)) u_bit (
    .clk(clk), .rst(rst), .i_load(w_bit_load), .i_dec(w_bit_dec),
    .i_val(w_idx), .o_cnt(w_bit_cnt), .o_zero(w_bit_zero));
  seq_down_cnt #(.W(GAP_W)) u_gap (
    .clk(clk), .rst(rst), .i_load(w_gap_load), .i_dec(w_gap_dec),
    .i_val(r_gap - 1'b1), .o_cnt(w_gap_cnt), .o_zero(w_gap_zero));
  seq_down_cnt #(.W(REP_W)) u_frm (
    .clk(clk), .rst(rst), .i_load(w_frm_load), .i_dec(w_frm_dec),
    .i_val(bus.reps - 1'b1), .o_cnt(w_frm_cnt), .o_zero(w_frm_zero));

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state <= IDLE;
      r_pat   <= '0;
      r_len   <= '0;
      r_gap   <= '0;
      r_out   <= 1'b0;
      r_valid <= 1'b0;
      r_sof   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_nxt;
      if (w_latch) begin
        r_pat <= bus.pat;
        r_len <= w_len_c;
        r_gap <= bus.gap;
      end
      r_out   <= (w_nxt == SEND) & w_shift[0];
      r_valid <= (w_nxt == SEND);
      r_sof   <= w_sof;
      r_busy  <= (w_nxt == SEND) || (w_nxt == GAP);
      r_done  <= (w_nxt == FIN);
    end

  assign bus.out       = r_out;
  assign bus.out_valid = r_valid;
  assign bus.frame_sof = r_sof;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
endmodule

// File: tb/tb_seq_pattern_gen.sv
// tb_seq_pattern_gen: directed checks of seq_pattern_gen with hand-computed per-cycle outputs.
module tb_seq_pattern_gen;
  logic clk, rst;
  int n_cmp = 0;
  int n_err = 0;

  seq_pattern_gen_if bus ();
  seq_pattern_gen dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // observed vector order: {out, out_valid, frame_sof, busy, done}
  task automatic chk(input string tag, input int cyc, input logic [4:0] got, input logic [4:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s cycle %0d: observed %b expected %b (out,val,sof,busy,done)", tag, cyc, got, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int got, input int exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // bit n-1 of each expectation word is the first checked cycle
  task automatic run(input string tag, input int n, input logic [31:0] e_out, input logic [31:0] e_val,
                     input logic [31:0] e_sof, input logic [31:0] e_busy, input logic [31:0] e_done);
    for (int i = n - 1; i >= 0; i--) begin
      chk(tag, n - i, {bus.out, bus.out_valid, bus.frame_sof, bus.busy, bus.done},
          {e_out[i], e_val[i], e_sof[i], e_busy[i], e_done[i]});
      @(posedge clk); #1;
    end
  endtask

  task automatic go(input logic [7:0] p, input logic [3:0] l, input logic [7:0] r, input logic [3:0] g);
    bus.pat = p; bus.len = l; bus.reps = r; bus.gap = g; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  initial begin
    int busy_cnt;
    logic seen_done;
    rst = 1'b0;
    bus.start = 1'b0; bus.abort = 1'b0;
    bus.pat = '0; bus.len = '0; bus.reps = '0; bus.gap = '0;
    #12;
    chk("reset", 0, {bus.out, bus.out_valid, bus.frame_sof, bus.busy, bus.done}, 5'b00000);
    rst = 1'b1;
    @(posedge clk); #1;

    go(8'b101, 4'd3, 8'd1, 4'd0);
    run("p101_r1", 5, 5'b10100, 5'b11100, 5'b10000, 5'b11100, 5'b00010);

    go(8'b101, 4'd3, 8'd2, 4'd0);
    run("p101_r2", 8, 8'b10110100, 8'b11111100, 8'b10010000, 8'b11111100, 8'b00000010);

    go(8'hA5, 4'd8, 8'd2, 4'd2);
    run("pA5_gap2", 20,
        20'b10100101_00_10100101_0_0, 20'b11111111_00_11111111_0_0,
        20'b10000000_00_10000000_0_0, 20'b11111111_11_11111111_0_0,
        20'b00000000_00_00000000_1_0);

    go(8'hFF, 4'd0, 8'd3, 4'd0);
    run("len0", 2, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10);
    go(8'hFF, 4'd3, 8'd0, 4'd1);
    run("reps0", 2, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10);

    go(8'h81, 4'd12, 8'd1, 4'd0);
    run("len12_clamp", 10, 10'b10000001_00, 10'b11111111_00, 10'b10000000_00,
        10'b11111111_00, 10'b00000000_10);

    go(8'hA5, 4'd8, 8'd1, 4'd0);
    run("abort_pre", 1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    bus.abort = 1'b1; bus.start = 1'b1;
    bus.pat = 8'b101; bus.len = 4'd3; bus.reps = 8'd1; bus.gap = 4'd0;
    run("abort_cyc2", 1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    bus.abort = 1'b0;
    run("abort_idle", 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.start = 1'b0;
    run("after_abort", 5, 5'b10100, 5'b11100, 5'b10000, 5'b11100, 5'b00010);

    go(8'b101, 4'd3, 8'd1, 4'd0);
    bus.start = 1'b1; bus.pat = 8'hFF; bus.len = 4'd8;
    run("start_busy", 3, 3'b101, 3'b111, 3'b100, 3'b111, 3'b000);
    run("start_fin", 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    run("start_idle", 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.start = 1'b0;
    run("restart_ff", 9, 9'b11111111_0, 9'b11111111_0, 9'b10000000_0,
        9'b11111111_0, 9'b00000000_1);

    go(8'h01, 4'd1, 8'd255, 4'd0);
    busy_cnt = 0;
    seen_done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (bus.done) begin
        seen_done = 1'b1;
        break;
      end
      if (bus.busy) busy_cnt++;
      @(posedge clk); #1;
    end
    chk_int("reps255_done", int'(seen_done), 1);
    chk_int("reps255_busy_cycles", busy_cnt, 255);
    @(posedge clk); #1;

    go(8'hA5, 4'd8, 8'd1, 4'd0);
    run("rst_pre", 2, 2'b10, 2'b11, 2'b10, 2'b11, 2'b00);
    #3 rst = 1'b0;
    #1;
    chk("async_rst", 0, {bus.out, bus.out_valid, bus.frame_sof, bus.busy, bus.done}, 5'b00000);
    @(posedge clk); #1;
    rst = 1'b1;
    run("post_rst", 3, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
